// File: rtl/rv32im_ifetch_pkg.sv
// Shared constants and types for the rv32im instruction fetch unit.
// The reset PC and instruction geometry live here so fetch and decode agree on them.
package rv32im_ifetch_pkg;

  localparam int unsigned API_PC_WIDTH   = 32;
  localparam int unsigned API_INST_WIDTH = 32;

  localparam logic [API_PC_WIDTH-1:0] API_RESET_PC = 32'h0000_0000;
  localparam logic [API_PC_WIDTH-1:0] API_PC_INC   = 32'd4;

  // One buffered fetch result; the packed layout is {err, pc, inst}.
  typedef struct packed {
    logic                      err;
    logic [API_PC_WIDTH-1:0]   pc;
    logic [API_INST_WIDTH-1:0] inst;
  } inst_entry_t;

  localparam int unsigned INST_ENTRY_WIDTH = $bits(inst_entry_t);

  function automatic logic [API_PC_WIDTH-1:0] align_pc(input logic [API_PC_WIDTH-1:0] pc);
    return pc & ~API_PC_WIDTH'(3);
  endfunction

endpackage

// File: rtl/rv32im_sync_fifo.sv
// Single-clock FIFO with synchronous flush and an occupancy count.
// The read port shows zero while empty so downstream outputs have defined reset values.
module rv32im_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop_i && (count_q != '0) && !flush_i;
  assign do_push = push_i && !flush_i && ((count_q != CntW'(DEPTH)) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/rv32im_ifetch.sv
// Instruction fetch: sequential PC, credit-limited imem requests, response buffering
// and discard of responses that were in flight when fetch was redirected.
module rv32im_ifetch
  import rv32im_ifetch_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_OUTST  = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      redirect_valid_i,
  input  logic [API_PC_WIDTH-1:0]   redirect_pc_i,
  output logic                      imem_req_valid_o,
  input  logic                      imem_req_ready_i,
  output logic [API_PC_WIDTH-1:0]   imem_req_addr_o,
  input  logic                      imem_rsp_valid_i,
  input  logic [API_INST_WIDTH-1:0] imem_rsp_data_i,
  input  logic                      imem_rsp_err_i,
  output logic                      inst_valid_o,
  input  logic                      inst_ready_i,
  output logic [API_INST_WIDTH-1:0] inst_o,
  output logic [API_PC_WIDTH-1:0]   inst_pc_o,
  output logic                      inst_err_o
);

  localparam int unsigned OutstW = $clog2(MAX_OUTST + 1);
  localparam int unsigned FcntW  = $clog2(FIFO_DEPTH + 1);

  logic [API_PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [OutstW-1:0]       outst;
  logic [OutstW-1:0]       drop_q, drop_d;
  logic [FcntW-1:0]        fifo_cnt;
  logic [API_PC_WIDTH-1:0] rsp_pc;
  inst_entry_t             push_entry, head_entry;
  logic                    credit_ok, req_hs, drop_active, inst_push, inst_pop;

  // Outstanding requests are exactly the entries of the in-flight PC FIFO.
  rv32im_sync_fifo #(
    .WIDTH (API_PC_WIDTH),
    .DEPTH (MAX_OUTST)
  ) u_pc_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (1'b0),
    .push_i  (req_hs),
    .wdata_i (fetch_pc_q),
    .pop_i   (imem_rsp_valid_i),
    .rdata_o (rsp_pc),
    .count_o (outst)
  );

  // Every non-discarded in-flight request already owns a slot here.
  assign credit_ok = (32'(fifo_cnt) + 32'(outst) - 32'(drop_q)) < FIFO_DEPTH;

  // Gating with reset_n keeps the request deasserted for the whole reset window.
  assign imem_req_valid_o = reset_n && !redirect_valid_i && (32'(outst) < MAX_OUTST) &&
                            credit_ok;
  assign imem_req_addr_o  = fetch_pc_q;
  assign req_hs           = imem_req_valid_o && imem_req_ready_i;

  assign drop_active = (drop_q != '0);
  assign inst_push   = imem_rsp_valid_i && !drop_active;
  assign inst_pop    = inst_valid_o && inst_ready_i;

  always_comb begin
    push_entry      = '0;
    push_entry.err  = imem_rsp_err_i;
    push_entry.pc   = rsp_pc;
    push_entry.inst = imem_rsp_data_i;
  end

  rv32im_sync_fifo #(
    .WIDTH (INST_ENTRY_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_inst_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (redirect_valid_i),
    .push_i  (inst_push),
    .wdata_i (push_entry),
    .pop_i   (inst_pop),
    .rdata_o (head_entry),
    .count_o (fifo_cnt)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    if (redirect_valid_i) begin
      fetch_pc_d = align_pc(redirect_pc_i);
      // No request issues in a redirect cycle, so only an arriving response shrinks outst.
      drop_d     = outst - OutstW'(imem_rsp_valid_i);
    end else begin
      if (req_hs) fetch_pc_d = fetch_pc_q + API_PC_INC;
      if (imem_rsp_valid_i && drop_active) drop_d = drop_q - OutstW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= API_RESET_PC;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
    end
  end

  assign inst_valid_o = (fifo_cnt != '0);
  assign inst_o       = head_entry.inst;
  assign inst_pc_o    = head_entry.pc;
  assign inst_err_o   = head_entry.err;

endmodule

// File: tb/tb_rv32im_ifetch.sv
// Scoreboard bench for rv32im_ifetch: an in-order imem model with random latency feeds
// the DUT; a reference model predicts requests and delivered instructions.
module tb_rv32im_ifetch;

  localparam int FIFO_DEPTH = 4;
  localparam int MAX_OUTST  = 2;

  logic        clk, reset_n;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_valid_o, imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        imem_rsp_err_i;
  logic        inst_valid_o, inst_ready_i;
  logic [31:0] inst_o, inst_pc_o;
  logic        inst_err_o;

  rv32im_ifetch #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .MAX_OUTST  (MAX_OUTST)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .imem_rsp_err_i   (imem_rsp_err_i),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready_i),
    .inst_o           (inst_o),
    .inst_pc_o        (inst_pc_o),
    .inst_err_o       (inst_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];      // instructions the DUT should be holding, oldest first
  logic [31:0] fl_pc[$];      // model of issued requests awaiting a response
  bit          fl_stale[$];   // set when a redirect made that request obsolete
  logic [31:0] mem_addr[$];
  int          mem_due[$];
  logic [31:0] hs_log[$];
  logic [31:0] exp_pc;
  exp_t        mon_e;
  int          cyc, last_due, rsp_num, err_target, err_seen;
  int unsigned lat_min, lat_max, req_rdy_pct, inst_rdy_pct;
  bit          rand_err, mon_en;
  int          n_checks, n_fail;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // mode: 0 no redirect, 1 redirect, 2 redirect only with a response and a pop, 3 random
  task automatic drive_cycle(input int mode, input logic [31:0] rpc, output bit did_redir);
    bit          rsp, redir, hs, exp_rv, stale, rerr;
    int          live, due;
    logic [31:0] pc, rdata, dummy_a;
    int          dummy_d;
    exp_t        e;
    @(negedge clk);
    cyc++;
    rsp   = (mem_due.size() != 0) && (mem_due[0] <= cyc);
    rerr  = 1'b0;
    rdata = $urandom;
    if (rsp) begin
      rsp_num++;
      rerr  = (rsp_num == err_target) || (rand_err && ($urandom_range(7) == 0));
      rdata = data_of(mem_addr[0]);
    end
    imem_rsp_valid_i = rsp;
    imem_rsp_data_i  = rdata;
    imem_rsp_err_i   = rerr;
    imem_req_ready_i = $urandom_range(99) < req_rdy_pct;
    inst_ready_i     = $urandom_range(99) < inst_rdy_pct;
    case (mode)
      1:       redir = 1'b1;
      2:       redir = rsp && inst_valid_o && inst_ready_i;
      3:       redir = ($urandom_range(15) == 0);
      default: redir = 1'b0;
    endcase
    redirect_valid_i = redir;
    redirect_pc_i    = rpc;
    did_redir        = redir;
    #1;
    live = 0;
    foreach (fl_stale[i]) if (!fl_stale[i]) live++;
    exp_rv = !redir && (fl_pc.size() < MAX_OUTST) && ((exp_q.size() + live) < FIFO_DEPTH);
    check("req_valid", 64'(imem_req_valid_o), 64'(exp_rv));
    check("inst_valid", 64'(inst_valid_o), 64'(exp_q.size() != 0));
    check("outst_bound", 64'(fl_pc.size() <= MAX_OUTST), 64'(1));
    check("fifo_bound", 64'(exp_q.size() <= FIFO_DEPTH), 64'(1));
    hs = imem_req_valid_o && imem_req_ready_i;
    if (hs) begin
      check("req_addr", 64'(imem_req_addr_o), 64'(exp_pc));
      hs_log.push_back(imem_req_addr_o);
    end
    if (rsp) begin
      stale   = fl_stale.pop_front();
      pc      = fl_pc.pop_front();
      dummy_a = mem_addr.pop_front();
      dummy_d = mem_due.pop_front();
      if (!stale && !redir) begin
        e.inst = data_of(pc);
        e.pc   = pc;
        e.err  = rerr;
        exp_q.push_back(e);
      end
    end
    if (hs) begin
      fl_pc.push_back(exp_pc);
      fl_stale.push_back(1'b0);
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_addr.push_back(imem_req_addr_o);
      mem_due.push_back(due);
      exp_pc = exp_pc + 32'd4;
    end
    if (redir) begin
      foreach (fl_stale[i]) fl_stale[i] = 1'b1;
      exp_q.delete();
      exp_pc = rpc & 32'hFFFF_FFFC;
    end
  endtask

  task automatic expect_first_pc(input string name, input logic [31:0] pc);
    bit found, d;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      drive_cycle(0, 32'h0, d);
      if (inst_valid_o) begin
        check(name, 64'(inst_pc_o), 64'(pc));
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: actual no instruction delivered, required pc %0h", name, pc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 64'(imem_req_valid_o), 64'(0));
    check({tag, "_req_addr"}, 64'(imem_req_addr_o), 64'(32'h0));
    check({tag, "_inst_valid"}, 64'(inst_valid_o), 64'(0));
    check({tag, "_inst"}, 64'(inst_o), 64'(0));
    check({tag, "_inst_pc"}, 64'(inst_pc_o), 64'(0));
    check({tag, "_inst_err"}, 64'(inst_err_o), 64'(0));
  endtask

  // Monitor: pops the scoreboard whenever decode consumes an instruction.
  always @(negedge clk) begin
    #2;
    if (mon_en && inst_valid_o && inst_ready_i && !redirect_valid_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_pop: actual pop of pc %0h, required no entry available", inst_pc_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("inst", 64'(inst_o), 64'(mon_e.inst));
        check("inst_pc", 64'(inst_pc_o), 64'(mon_e.pc));
        check("inst_err", 64'(inst_err_o), 64'(mon_e.err));
        if (inst_err_o) err_seen++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit d;
    int err_base;
    n_checks = 0; n_fail = 0; cyc = 0; last_due = 0; rsp_num = 0; err_target = -1;
    err_seen = 0; rand_err = 1'b0; mon_en = 1'b0;
    lat_min = 1; lat_max = 1; req_rdy_pct = 100; inst_rdy_pct = 100;
    exp_pc = 32'h0;
    reset_n = 1'b0;
    redirect_valid_i = 1'b0; redirect_pc_i = 32'h0;
    imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b0; imem_rsp_data_i = 32'h0;
    imem_rsp_err_i = 1'b0; inst_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("rst");
    reset_n = 1'b1;
    #1;
    check("first_req", 64'(imem_req_valid_o), 64'(1));
    mon_en = 1'b1;

    // Streaming with single-cycle memory
    repeat (30) drive_cycle(0, 32'h0, d);
    if (hs_log.size() >= 3) begin
      check("t1_addr0", 64'(hs_log[0]), 64'(32'h0));
      check("t1_addr1", 64'(hs_log[1]), 64'(32'h4));
      check("t1_addr2", 64'(hs_log[2]), 64'(32'h8));
    end else begin
      n_checks++; n_fail++;
      $display("FAIL t1_addrs: actual %0d requests, required at least 3", hs_log.size());
    end

    // Decode stall fills the buffer and stops fetch
    inst_rdy_pct = 0;
    repeat (20) drive_cycle(0, 32'h0, d);
    check("t2_held", 64'(exp_q.size()), 64'(FIFO_DEPTH));
    check("t2_req_idle", 64'(imem_req_valid_o), 64'(0));
    check("t2_valid", 64'(inst_valid_o), 64'(1));
    inst_rdy_pct = 100;
    repeat (15) drive_cycle(0, 32'h0, d);

    // Redirect with two requests in flight
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && fl_pc.size() != 2; i++) drive_cycle(0, 32'h0, d);
    check("t3_inflight", 64'(fl_pc.size()), 64'(2));
    hs_log.delete();
    drive_cycle(1, 32'h0000_1002, d);
    expect_first_pc("t3_first_pc", 32'h0000_1000);
    check("t3_next_addr", 64'(hs_log.size() != 0 ? hs_log[0] : 32'hDEAD_BEEF),
          64'(32'h0000_1000));

    // Redirect coinciding with a response and a pop
    lat_min = 1; lat_max = 1;
    repeat (6) drive_cycle(0, 32'h0, d);
    for (int i = 0; i < 30; i++) begin
      drive_cycle(2, 32'h0000_2000, d);
      if (d) break;
    end
    check("t4_hit", 64'(d), 64'(1));
    drive_cycle(0, 32'h0, d);
    check("t4_flushed", 64'(inst_valid_o), 64'(0));
    expect_first_pc("t4_first_pc", 32'h0000_2000);

    // PC wrap
    repeat (6) drive_cycle(0, 32'h0, d);
    hs_log.delete();
    drive_cycle(1, 32'hFFFF_FFF8, d);
    repeat (10) drive_cycle(0, 32'h0, d);
    if (hs_log.size() >= 3) begin
      check("t5_addr0", 64'(hs_log[0]), 64'(32'hFFFF_FFF8));
      check("t5_addr1", 64'(hs_log[1]), 64'(32'hFFFF_FFFC));
      check("t5_addr2", 64'(hs_log[2]), 64'(32'h0000_0000));
    end else begin
      n_checks++; n_fail++;
      $display("FAIL t5_addrs: actual %0d requests, required at least 3", hs_log.size());
    end

    // Access fault on the second response
    err_base   = err_seen;
    err_target = rsp_num + 2;
    repeat (15) drive_cycle(0, 32'h0, d);
    check("t6_err_count", 64'(err_seen - err_base), 64'(1));

    // Random traffic with redirects, backpressure and faults
    rand_err = 1'b1; lat_min = 1; lat_max = 3; req_rdy_pct = 70; inst_rdy_pct = 60;
    for (int i = 0; i < 400; i++) begin
      drive_cycle(3, (($urandom_range(3) == 0) ? 32'hFFFF_FF00 : 32'h0000_4000) +
                     32'($urandom_range(255)), d);
    end

    // Asynchronous reset in the middle of traffic
    rand_err = 1'b0; req_rdy_pct = 100; inst_rdy_pct = 0;
    repeat (8) drive_cycle(0, 32'h0, d);
    check("pre_reset_valid", 64'(inst_valid_o), 64'(1));
    #2;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
